// File: rtl/decode.sv
// Decode stage: splits the instruction into ALU/write-back control and
// immediate fields, and holds the pixel, constant and multiply register files.
module decode #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instruction,
  input  logic         wr_pos_pxl,
  input  logic         we_pxl,
  input  logic         we_mul,
  input  logic [W-1:0] wdp1,
  input  logic [W-1:0] wdp2,
  input  logic [W-1:0] wdp3,
  input  logic [W-1:0] wdp4,
  input  logic [W-1:0] wdm1,
  input  logic [W-1:0] wdm2,
  input  logic [W-1:0] wdm3,
  input  logic [W-1:0] wdm4,
  input  logic         wr_mul_pos_in,
  output logic         wr_pxl,
  output logic         wr_pos,
  output logic         wr_mul_reg,
  output logic         alu_func,
  output logic         wr_wom,
  output logic [W-1:0] pix_out1,
  output logic [W-1:0] pix_out2,
  output logic [W-1:0] pix_out3,
  output logic [W-1:0] pix_out4,
  output logic [W-1:0] cte_out1,
  output logic [W-1:0] cte_out2,
  output logic [W-1:0] cte_out3,
  output logic [W-1:0] cte_out4,
  output logic [W-1:0] mul_out1,
  output logic [W-1:0] mul_out2,
  output logic [W-1:0] mul_out3,
  output logic [W-1:0] mul_out4,
  output logic [W-1:0] mul_out5,
  output logic [W-1:0] mul_out6,
  output logic [W-1:0] mul_out7,
  output logic [W-1:0] mul_out8,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic [W-1:0] n,
  output logic [W-1:0] wom_addr,
  output logic         wr_mul_pos_out
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_LDC   = 4'b0001,
    OP_SUMFV = 4'b0011,
    OP_MULFV = 4'b0100,
    OP_STW   = 4'b0101
  } opcode_t;

  opcode_t     op;
  logic        ps;
  logic        md;
  logic [1:0]  ci;
  logic [15:0] imm16;

  logic [W-1:0] pixel [2][4];
  logic [W-1:0] cte   [4];
  logic [W-1:0] mul   [2][4];

  assign op    = opcode_t'(instruction[31:28]);
  assign ps    = instruction[27];
  assign md    = instruction[26];
  assign ci    = instruction[25:24];
  assign imm16 = instruction[15:0];

  assign i        = W'(instruction[23:16]);
  assign j        = W'(instruction[15:8]);
  assign n        = W'(instruction[7:0]);
  assign wom_addr = W'(imm16);

  // Control decode; unlisted opcodes fall through to all-zero (NOP).
  always_comb begin
    wr_pxl         = 1'b0;
    wr_pos         = 1'b0;
    wr_mul_reg     = 1'b0;
    alu_func       = 1'b0;
    wr_wom         = 1'b0;
    wr_mul_pos_out = 1'b0;
    case (op)
      OP_SUMFV: begin
        alu_func = 1'b0;
        wr_pxl   = 1'b1;
        wr_pos   = ps;
      end
      OP_MULFV: begin
        alu_func       = 1'b1;
        wr_mul_reg     = 1'b1;
        wr_mul_pos_out = md;
      end
      OP_STW:  wr_wom = 1'b1;
      default: ;
    endcase
  end

  // Register-file updates; reset overrides both write ports and LDC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel <= '{default: '0};
      cte   <= '{default: '0};
      mul   <= '{default: '0};
    end else begin
      if (we_pxl) begin
        pixel[wr_pos_pxl][0] <= wdp1;
        pixel[wr_pos_pxl][1] <= wdp2;
        pixel[wr_pos_pxl][2] <= wdp3;
        pixel[wr_pos_pxl][3] <= wdp4;
      end
      if (we_mul) begin
        mul[wr_mul_pos_in][0] <= wdm1;
        mul[wr_mul_pos_in][1] <= wdm2;
        mul[wr_mul_pos_in][2] <= wdm3;
        mul[wr_mul_pos_in][3] <= wdm4;
      end
      if (op == OP_LDC)
        cte[ci] <= W'(imm16);
    end
  end

  assign pix_out1 = pixel[ps][0];
  assign pix_out2 = pixel[ps][1];
  assign pix_out3 = pixel[ps][2];
  assign pix_out4 = pixel[ps][3];

  assign cte_out1 = cte[0];
  assign cte_out2 = cte[1];
  assign cte_out3 = cte[2];
  assign cte_out4 = cte[3];

  assign mul_out1 = mul[0][0];
  assign mul_out2 = mul[0][1];
  assign mul_out3 = mul[0][2];
  assign mul_out4 = mul[0][3];
  assign mul_out5 = mul[1][0];
  assign mul_out6 = mul[1][1];
  assign mul_out7 = mul[1][2];
  assign mul_out8 = mul[1][3];

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage register files and control decode.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        wr_pos_pxl, we_pxl, we_mul, wr_mul_pos_in;
  logic [31:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;
  logic        wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom, wr_mul_pos_out;
  logic [31:0] pix_out1, pix_out2, pix_out3, pix_out4;
  logic [31:0] cte_out1, cte_out2, cte_out3, cte_out4;
  logic [31:0] mul_out1, mul_out2, mul_out3, mul_out4;
  logic [31:0] mul_out5, mul_out6, mul_out7, mul_out8;
  logic [31:0] i, j, n, wom_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode #(.W(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .wr_pos_pxl(wr_pos_pxl), .we_pxl(we_pxl), .we_mul(we_mul),
    .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
    .wr_mul_pos_in(wr_mul_pos_in),
    .wr_pxl(wr_pxl), .wr_pos(wr_pos), .wr_mul_reg(wr_mul_reg),
    .alu_func(alu_func), .wr_wom(wr_wom),
    .pix_out1(pix_out1), .pix_out2(pix_out2), .pix_out3(pix_out3), .pix_out4(pix_out4),
    .cte_out1(cte_out1), .cte_out2(cte_out2), .cte_out3(cte_out3), .cte_out4(cte_out4),
    .mul_out1(mul_out1), .mul_out2(mul_out2), .mul_out3(mul_out3), .mul_out4(mul_out4),
    .mul_out5(mul_out5), .mul_out6(mul_out6), .mul_out7(mul_out7), .mul_out8(mul_out8),
    .i(i), .j(j), .n(n), .wom_addr(wom_addr),
    .wr_mul_pos_out(wr_mul_pos_out)
  );

  // Control bundle: {wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom, wr_mul_pos_out}
  logic [5:0] ctrl;
  assign ctrl = {wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom, wr_mul_pos_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix1"}, pix_out1, 0); chk({tag, "_pix2"}, pix_out2, 0);
    chk({tag, "_pix3"}, pix_out3, 0); chk({tag, "_pix4"}, pix_out4, 0);
    chk({tag, "_cte1"}, cte_out1, 0); chk({tag, "_cte2"}, cte_out2, 0);
    chk({tag, "_cte3"}, cte_out3, 0); chk({tag, "_cte4"}, cte_out4, 0);
    chk({tag, "_mul1"}, mul_out1, 0); chk({tag, "_mul2"}, mul_out2, 0);
    chk({tag, "_mul3"}, mul_out3, 0); chk({tag, "_mul4"}, mul_out4, 0);
    chk({tag, "_mul5"}, mul_out5, 0); chk({tag, "_mul6"}, mul_out6, 0);
    chk({tag, "_mul7"}, mul_out7, 0); chk({tag, "_mul8"}, mul_out8, 0);
  endtask

  initial begin
    rst = 1'b0; instruction = 32'h0;
    wr_pos_pxl = 1'b0; we_pxl = 1'b0; we_mul = 1'b0; wr_mul_pos_in = 1'b0;
    wdp1 = 0; wdp2 = 0; wdp3 = 0; wdp4 = 0;
    wdm1 = 0; wdm2 = 0; wdm3 = 0; wdm4 = 0;

    // Reset then read
    #2;
    tick;
    chk_all_zero("reset");
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    rst = 1'b1;

    // Multiply file, both rows
    we_mul = 1'b1; wr_mul_pos_in = 1'b0;
    wdm1 = 15; wdm2 = 16; wdm3 = 17; wdm4 = 18;
    tick;
    chk("mul_row0_early_row1", mul_out5, 0);
    wr_mul_pos_in = 1'b1;
    wdm1 = 150; wdm2 = 160; wdm3 = 170; wdm4 = 180;
    tick;
    we_mul = 1'b0;
    wdm1 = 32'hDEAD; wdm2 = 32'hDEAD; wdm3 = 32'hDEAD; wdm4 = 32'hDEAD;
    tick; tick;
    chk("mul1", mul_out1, 15);  chk("mul2", mul_out2, 16);
    chk("mul3", mul_out3, 17);  chk("mul4", mul_out4, 18);
    chk("mul5", mul_out5, 150); chk("mul6", mul_out6, 160);
    chk("mul7", mul_out7, 170); chk("mul8", mul_out8, 180);

    // Pixel file and row select
    we_pxl = 1'b1; wr_pos_pxl = 1'b0;
    wdp1 = 15; wdp2 = 16; wdp3 = 17; wdp4 = 18;
    tick;
    wr_pos_pxl = 1'b1;
    wdp1 = 150; wdp2 = 160; wdp3 = 170; wdp4 = 180;
    tick;
    we_pxl = 1'b0;
    instruction = 32'h4C000000;
    #1;
    chk("mulfv_pix1", pix_out1, 150); chk("mulfv_pix2", pix_out2, 160);
    chk("mulfv_pix3", pix_out3, 170); chk("mulfv_pix4", pix_out4, 180);
    chk("mulfv_ctrl", 32'(ctrl), 32'b001101);
    instruction = 32'h30000000;
    #1;
    chk("sumfv_pix1", pix_out1, 15); chk("sumfv_pix2", pix_out2, 16);
    chk("sumfv_pix3", pix_out3, 17); chk("sumfv_pix4", pix_out4, 18);
    chk("sumfv_ctrl", 32'(ctrl), 32'b100000);
    instruction = 32'h38000000;
    #1;
    chk("sumfv_ps1_ctrl", 32'(ctrl), 32'b110000);

    // LDC and immediate fields
    instruction = 32'h12AB1234;
    #1;
    chk("ldc_i", i, 32'hAB);
    chk("ldc_j", j, 32'h12);
    chk("ldc_n", n, 32'h34);
    chk("ldc_wom_addr", wom_addr, 32'h1234);
    chk("ldc_ctrl", 32'(ctrl), 32'h0);
    chk("ldc_no_bypass", cte_out3, 0);
    tick;
    instruction = 32'h0;
    chk("ldc_cte3", cte_out3, 32'h1234);
    chk("ldc_cte1", cte_out1, 0);
    chk("ldc_cte4", cte_out4, 0);

    // STW and illegal opcodes
    instruction = 32'h50000040;
    #1;
    chk("stw_ctrl", 32'(ctrl), 32'b000010);
    chk("stw_wom_addr", wom_addr, 64);
    instruction = 32'hF0000000;
    #1;
    chk("illegal_F_ctrl", 32'(ctrl), 32'h0);
    instruction = 32'h2C000000;
    #1;
    chk("illegal_2_ctrl", 32'(ctrl), 32'h0);
    instruction = 32'h6C000000;
    #1;
    chk("illegal_6_ctrl", 32'(ctrl), 32'h0);

    // Simultaneous pixel + multiply writes with an LDC in the same cycle
    instruction = 32'h13005555;
    we_pxl = 1'b1; wr_pos_pxl = 1'b0;
    wdp1 = 1; wdp2 = 2; wdp3 = 3; wdp4 = 4;
    we_mul = 1'b1; wr_mul_pos_in = 1'b1;
    wdm1 = 5; wdm2 = 6; wdm3 = 7; wdm4 = 8;
    tick;
    chk("sim_pix1", pix_out1, 1); chk("sim_pix4", pix_out4, 4);
    chk("sim_mul5", mul_out5, 5); chk("sim_mul8", mul_out8, 8);
    chk("sim_mul1_kept", mul_out1, 15);
    chk("sim_cte4", cte_out4, 32'h5555);
    chk("sim_cte3_kept", cte_out3, 32'h1234);

    // Reset mid-sequence with writes and LDC pending
    rst = 1'b0;
    we_pxl = 1'b1; wr_pos_pxl = 1'b1;
    wdp1 = 9; wdp2 = 9; wdp3 = 9; wdp4 = 9;
    we_mul = 1'b1; wr_mul_pos_in = 1'b0;
    wdm1 = 9; wdm2 = 9; wdm3 = 9; wdm4 = 9;
    tick;
    rst = 1'b1; we_pxl = 1'b0; we_mul = 1'b0;
    instruction = 32'h0;
    #1;
    chk_all_zero("midrst");
    instruction = 32'h08000000;
    #1;
    chk("midrst_pix_row1", pix_out1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
